// File: rtl/ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ctrl_pkg                                                        |
// | Brief    : Shared types and constants for the filter-group load path.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        FIN   = 3'd3,
        DONE  = 3'd4
    } fil_ld_state_t;

    localparam int MAX_FIL_GROUPS = 4;
    localparam int FIL_WORDS      = 9;

endpackage
`default_nettype wire

// File: rtl/ctrl_cnt_wr_addr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ctrl_cnt_wr_addr                                                |
// | Brief    : Word/group write-address counter with wrap and last flags.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ctrl_cnt_wr_addr #(
    parameter int WORDS  = 9,
    parameter int ADDR_W = 4,
    parameter int GRP_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_inc,
    input  logic [2:0]        i_num_groups,
    output logic [ADDR_W-1:0] o_word,
    output logic [GRP_W-1:0]  o_group,
    output logic              o_last_word,
    output logic              o_last_group
);

    logic [ADDR_W-1:0] r_word;
    logic [GRP_W-1:0]  r_group;

    assign o_word       = r_word;
    assign o_group      = r_group;
    assign o_last_word  = (r_word == ADDR_W'(WORDS - 1));
    assign o_last_group = (3'(r_group) == (i_num_groups - 3'd1));

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_word  <= '0;
            r_group <= '0;
        end else if (i_inc) begin
            if (o_last_word) begin
                r_word  <= '0;
                r_group <= r_group + GRP_W'(1);
            end else begin
                r_word  <= r_word + ADDR_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_fil_group_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ctrl_fil_group_loader                                           |
// | Brief    : Streams filter words into per-group banks, then hands the       |
// |            group count to the group-select counter (clear, then load).     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ctrl_fil_group_loader
    import ctrl_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int MAX_GROUPS      = MAX_FIL_GROUPS,
    parameter int WORDS_PER_GROUP = FIL_WORDS,
    localparam int ADDR_W         = $clog2(WORDS_PER_GROUP),
    localparam int GRP_W          = $clog2(MAX_GROUPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            num_groups,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic [MAX_GROUPS-1:0] wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  grp_clear,
    output logic                  grp_load,
    output logic [2:0]            grp_max_val,
    output logic                  busy,
    output logic                  done,
    output logic                  err_cfg
);

    fil_ld_state_t          r_state;
    fil_ld_state_t          w_next_state;
    logic [2:0]             r_num_groups;
    logic [MAX_GROUPS-1:0]  r_wr_en;
    logic [ADDR_W-1:0]      r_wr_addr;
    logic [DATA_W-1:0]      r_wr_data;
    logic                   r_err_cfg;

    logic                   w_hs;
    logic                   w_cfg_ok;
    logic                   w_can_start;
    logic [ADDR_W-1:0]      w_word;
    logic [GRP_W-1:0]       w_group;
    logic                   w_last_word;
    logic                   w_last_group;

    assign w_cfg_ok    = (num_groups != 3'd0) && (int'(num_groups) <= MAX_GROUPS);
    assign w_can_start = (r_state == IDLE) || (r_state == DONE);
    assign w_hs        = in_valid && in_ready;

    ctrl_cnt_wr_addr #(
        .WORDS  (WORDS_PER_GROUP),
        .ADDR_W (ADDR_W),
        .GRP_W  (GRP_W)
    ) u_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (r_state == CLEAR),
        .i_inc        (w_hs),
        .i_num_groups (r_num_groups),
        .o_word       (w_word),
        .o_group      (w_group),
        .o_last_word  (w_last_word),
        .o_last_group (w_last_group)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: if (start && w_cfg_ok) w_next_state = CLEAR;
            CLEAR:      w_next_state = LOAD;
            LOAD:       if (w_hs && w_last_word && w_last_group) w_next_state = FIN;
            FIN:        w_next_state = DONE;
            default:    w_next_state = IDLE;
        endcase
    end

    // Write port is a pure 1-cycle register stage of the accepted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_groups <= 3'd0;
            r_wr_en      <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_err_cfg    <= 1'b0;
        end else begin
            r_err_cfg <= start && w_can_start && !w_cfg_ok;
            if (start && w_can_start && w_cfg_ok) begin
                r_num_groups <= num_groups;
            end
            r_wr_en <= w_hs ? (MAX_GROUPS'(1) << w_group) : '0;
            if (w_hs) begin
                r_wr_addr <= w_word;
                r_wr_data <= in_data;
            end
        end
    end

    assign in_ready    = (r_state == LOAD);
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign grp_clear   = (r_state == CLEAR);
    assign grp_load    = (r_state == FIN);
    assign grp_max_val = ((r_state == FIN) || (r_state == DONE)) ? r_num_groups : 3'd0;
    assign busy        = (r_state == CLEAR) || (r_state == LOAD) || (r_state == FIN);
    assign done        = (r_state == DONE);
    assign err_cfg     = r_err_cfg;

endmodule
`default_nettype wire
